// File: rtl/zet_wb_bridge_pkg.sv
// zet_wb_bridge_pkg: FSM state encoding and Wishbone byte-lane select constants
package zet_wb_bridge_pkg;

    typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;

    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;

endpackage

// File: rtl/zet_wb_bridge_lanes.sv
// zet_wb_lanes: byte-lane select, write-data steering and read-byte extraction
// ports: a0/byte_op/phase/dat in -> sel, wdat out; rd in -> rbyte out
module zet_wb_lanes
    import zet_wb_bridge_pkg::*;
(
    input  logic        a0,
    input  logic        byte_op,
    input  logic        phase,
    input  logic [15:0] dat,
    input  logic [15:0] rd,
    output logic [1:0]  sel,
    output logic [15:0] wdat,
    output logic [7:0]  rbyte
);

    // phase 1 only occurs on the second half of an odd word, which uses the low lane
    always_comb begin
        sel   = byte_op ? (a0 ? SEL_HI : SEL_LO) : !a0 ? SEL_W : phase ? SEL_LO : SEL_HI;
        wdat  = (!byte_op && !a0) ? dat : phase ? {dat[15:8], dat[15:8]} : {dat[7:0], dat[7:0]};
        rbyte = a0 ? rd[15:8] : rd[7:0];
    end

endmodule

// File: rtl/zet_wb_bridge.sv
// zet_wb_bridge: Zet core bus to 16-bit Wishbone master, splitting odd word accesses
// ports: clk, rst; cpu_* request in, cpu_block/cpu_dat_i/iid_dat_i out; wb_* master
module zet_wb_bridge
    import zet_wb_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] cpu_adr_o,
    input  logic [15:0] cpu_dat_o,
    input  logic        cpu_byte_o,
    input  logic        cpu_mem_op,
    input  logic        cpu_m_io,
    input  logic        cpu_we_o,
    output logic        cpu_block,
    output logic [15:0] cpu_dat_i,
    output logic [15:0] iid_dat_i,
    output logic [18:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    state_t      state, next;
    logic        a0_q, byte_q;
    logic [15:0] dat_q, rd_q;
    logic [7:0]  lo_q;
    logic        idle, odd, l_a0, l_byte;
    logic [15:0] l_dat, wdat;
    logic [1:0]  sel;
    logic [7:0]  rbyte;

    // lanes see the live request in IDLE and the latched access afterwards
    always_comb begin
        idle      = state == IDLE;
        odd       = !byte_q && a0_q;
        l_a0      = idle ? cpu_adr_o[0] : a0_q;
        l_byte    = idle ? cpu_byte_o : byte_q;
        l_dat     = idle ? cpu_dat_o : dat_q;
        next      = idle ? (cpu_mem_op ? CYC1 : IDLE)
                  : state == CYC1 ? (wb_ack_i ? (odd ? CYC2 : DONE) : CYC1)
                  : state == CYC2 ? (wb_ack_i ? DONE : CYC2) : IDLE;
        cpu_block = !rst && ((idle && cpu_mem_op) || state == CYC1 || state == CYC2);
        cpu_dat_i = rd_q;
        iid_dat_i = rd_q;
    end

    zet_wb_lanes lanes (
        .a0      (l_a0),
        .byte_op (l_byte),
        .phase   (state == CYC1),
        .dat     (l_dat),
        .rd      (wb_dat_i),
        .sel     (sel),
        .wdat    (wdat),
        .rbyte   (rbyte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a0_q     <= 1'b0;
            byte_q   <= 1'b0;
            dat_q    <= '0;
            rd_q     <= '0;
            lo_q     <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_tga_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            state <= next;
            if (idle && cpu_mem_op) begin
                a0_q     <= cpu_adr_o[0];
                byte_q   <= cpu_byte_o;
                dat_q    <= cpu_dat_o;
                wb_adr_o <= cpu_adr_o[19:1];
                wb_sel_o <= sel;
                wb_dat_o <= wdat;
                wb_we_o  <= cpu_we_o;
                wb_tga_o <= cpu_m_io;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end
            if (state == CYC1 && wb_ack_i) begin
                if (odd) begin
                    // cyc/stb stay high; only address, lanes and data move to the next word
                    wb_adr_o <= wb_adr_o + 19'd1;
                    wb_sel_o <= sel;
                    wb_dat_o <= wdat;
                    lo_q     <= rbyte;
                end else begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    if (!wb_we_o)
                        rd_q <= byte_q ? {8'h00, rbyte} : wb_dat_i;
                end
            end
            if (state == CYC2 && wb_ack_i) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                if (!wb_we_o)
                    rd_q <= {wb_dat_i[7:0], lo_q};
            end
        end
    end

endmodule

// File: tb/tb_zet_wb_bridge.sv
// tb_zet_wb_bridge: directed self-checking bench for zet_wb_bridge
module tb_zet_wb_bridge;

    logic        clk = 1'b0, rst = 1'b1;
    logic [19:0] cpu_adr_o = '0;
    logic [15:0] cpu_dat_o = '0;
    logic        cpu_byte_o = 1'b0, cpu_mem_op = 1'b0, cpu_m_io = 1'b0, cpu_we_o = 1'b0;
    logic        cpu_block;
    logic [15:0] cpu_dat_i, iid_dat_i;
    logic [18:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    zet_wb_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_adr_o(cpu_adr_o), .cpu_dat_o(cpu_dat_o), .cpu_byte_o(cpu_byte_o),
        .cpu_mem_op(cpu_mem_op), .cpu_m_io(cpu_m_io), .cpu_we_o(cpu_we_o),
        .cpu_block(cpu_block), .cpu_dat_i(cpu_dat_i), .iid_dat_i(iid_dat_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [19:0] a, input logic [15:0] d, input logic b, input logic we, input logic io);
        cpu_adr_o  = a;
        cpu_dat_o  = d;
        cpu_byte_o = b;
        cpu_we_o   = we;
        cpu_m_io   = io;
        cpu_mem_op = 1'b1;
        #1;
        chk("req_block", cpu_block, 1);
    endtask

    initial begin
        tick;
        cpu_mem_op = 1'b1;
        #1;
        chk("rst_block", cpu_block, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_tga", wb_tga_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_cpu_dat", cpu_dat_i, 0);
        chk("rst_iid_dat", iid_dat_i, 0);
        cpu_mem_op = 1'b0;
        rst = 1'b0;
        tick;

        req(20'h01234, 16'h0000, 0, 0, 0);
        tick;
        cpu_mem_op = 1'b0;
        #1;
        chk("al_cyc", wb_cyc_o, 1);
        chk("al_stb", wb_stb_o, 1);
        chk("al_adr", wb_adr_o, 19'h0091A);
        chk("al_sel", wb_sel_o, 2'b11);
        chk("al_we", wb_we_o, 0);
        chk("al_block1", cpu_block, 1);
        tick;
        chk("al_block2", cpu_block, 1);
        chk("al_cyc2", wb_cyc_o, 1);
        tick;
        chk("al_block3", cpu_block, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'hBEEF;
        tick;
        wb_ack_i = 1'b0;
        #1;
        chk("al_done_cyc", wb_cyc_o, 0);
        chk("al_done_stb", wb_stb_o, 0);
        chk("al_done_block", cpu_block, 0);
        chk("al_cpu_dat", cpu_dat_i, 16'hBEEF);
        chk("al_iid_dat", iid_dat_i, 16'hBEEF);
        tick;

        req(20'h00101, 16'h0000, 0, 0, 0);
        tick;
        cpu_mem_op = 1'b0;
        chk("odd_adr1", wb_adr_o, 19'h00080);
        chk("odd_sel1", wb_sel_o, 2'b10);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'hAA12;
        tick;
        chk("odd_cyc2", wb_cyc_o, 1);
        chk("odd_stb2", wb_stb_o, 1);
        chk("odd_adr2", wb_adr_o, 19'h00081);
        chk("odd_sel2", wb_sel_o, 2'b01);
        wb_dat_i = 16'h3455;
        tick;
        wb_ack_i = 1'b0;
        chk("odd_result", cpu_dat_i, 16'h55AA);
        chk("odd_iid", iid_dat_i, 16'h55AA);
        chk("odd_done_cyc", wb_cyc_o, 0);
        tick;

        req(20'h00201, 16'h0077, 1, 1, 1);
        tick;
        cpu_mem_op = 1'b0;
        chk("iow_sel", wb_sel_o, 2'b10);
        chk("iow_dat", wb_dat_o, 16'h7777);
        chk("iow_we", wb_we_o, 1);
        chk("iow_tga", wb_tga_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'hDEAD;
        tick;
        wb_ack_i = 1'b0;
        chk("iow_done_cyc", wb_cyc_o, 0);
        chk("iow_keep", cpu_dat_i, 16'h55AA);
        tick;

        req(20'hFFFFF, 16'h1234, 0, 1, 0);
        tick;
        cpu_mem_op = 1'b0;
        chk("wrap_adr1", wb_adr_o, 19'h7FFFF);
        chk("wrap_sel1", wb_sel_o, 2'b10);
        chk("wrap_dat1", wb_dat_o, 16'h3434);
        wb_ack_i = 1'b1;
        tick;
        chk("wrap_adr2", wb_adr_o, 19'h00000);
        chk("wrap_sel2", wb_sel_o, 2'b01);
        chk("wrap_dat2", wb_dat_o, 16'h1212);
        chk("wrap_cyc2", wb_cyc_o, 1);
        tick;
        wb_ack_i = 1'b0;
        chk("wrap_done_cyc", wb_cyc_o, 0);
        chk("wrap_keep", cpu_dat_i, 16'h55AA);
        tick;

        req(20'h00003, 16'h0000, 0, 0, 0);
        tick;
        cpu_mem_op = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 16'h9900;
        tick;
        wb_ack_i = 1'b0;
        chk("rc2_in_cyc2", wb_cyc_o, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("rc2_cyc", wb_cyc_o, 0);
        chk("rc2_stb", wb_stb_o, 0);
        chk("rc2_block", cpu_block, 0);
        chk("rc2_dat", cpu_dat_i, 16'h0000);
        req(20'h00010, 16'h0000, 0, 0, 0);
        tick;
        cpu_mem_op = 1'b0;
        chk("rc2_adr", wb_adr_o, 19'h00008);
        chk("rc2_sel", wb_sel_o, 2'b11);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'h1357;
        tick;
        wb_ack_i = 1'b0;
        chk("rc2_result", cpu_dat_i, 16'h1357);
        chk("rc2_done_block", cpu_block, 0);
        tick;

        cpu_adr_o  = 20'h00020;
        cpu_byte_o = 1'b0;
        cpu_we_o   = 1'b0;
        cpu_m_io   = 1'b0;
        cpu_mem_op = 1'b1;
        wb_ack_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b_idle_block", cpu_block, 1);
            chk("b2b_idle_cyc", wb_cyc_o, 0);
            wb_dat_i = 16'h1000 + 16'(i);
            tick;
            chk("b2b_cyc", wb_cyc_o, 1);
            chk("b2b_adr", wb_adr_o, 19'h00010);
            tick;
            chk("b2b_done_block", cpu_block, 0);
            chk("b2b_result", cpu_dat_i, 16'h1000 + 16'(i));
            tick;
        end
        cpu_mem_op = 1'b0;
        wb_ack_i   = 1'b0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
